// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: debounces the exec pushbutton and steps the
// phase counter through RUN / STEP / IDLE / HALTED, counting completed instructions.
module phase_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_PHASES      = 5,
    parameter int PHASE_W         = 3,
    parameter int CNT_W           = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec_n,
    input  logic               step_mode,
    input  logic               halt,
    output logic [PHASE_W-1:0] phase,
    output logic               running,
    output logic               halted,
    output logic               exec_pulse,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_sync1, r_sync2, r_db, r_pulse, r_stop;
    logic [DB_W-1:0]    r_db_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [CNT_W-1:0]   r_count;
    logic               w_db_flip, w_last, w_active;

    // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_db_flip = (r_sync2 != r_db) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_db     <= 1'b1;
            r_db_cnt <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1 <= exec_n;
            r_sync2 <= r_sync1;
            r_pulse <= w_db_flip & r_db;
            if (r_sync2 == r_db || w_db_flip)
                r_db_cnt <= '0;
            else
                r_db_cnt <= r_db_cnt + 1'b1;
            if (w_db_flip)
                r_db <= r_sync2;
        end
    end

    assign w_last = (r_phase == PH_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_pulse) w_state_nxt = step_mode ? S_STEP : S_RUN;
            S_RUN:    if (w_last) w_state_nxt = halt ? S_HALTED : (r_stop ? S_IDLE : S_RUN);
            S_STEP:   if (w_last) w_state_nxt = halt ? S_HALTED : S_IDLE;
            default:  w_state_nxt = S_HALTED;
        endcase
    end

    always_comb begin
        w_active = 1'b0;
        running  = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_RUN, S_STEP: begin w_active = 1'b1; running = 1'b1; end
            S_HALTED:      halted = 1'b1;
            default:       ;
        endcase
    end

    // A stop request only takes effect at the wrap, so an instruction always completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            r_count <= '0;
            r_stop  <= 1'b0;
        end else begin
            if (!w_active)   r_phase <= '0;
            else if (w_last) r_phase <= '0;
            else             r_phase <= r_phase + 1'b1;

            if (w_active && w_last)
                r_count <= r_count + 1'b1;

            if (r_state != S_RUN) r_stop <= 1'b0;
            else if (w_last)      r_stop <= ~halt & ~r_stop & r_pulse;
            else                  r_stop <= r_stop | r_pulse;
        end
    end

    assign phase       = r_phase;
    assign exec_pulse  = r_pulse;
    assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer against a behavioural model built on a
// sample-history window for the debouncer and instruction-level run/stop/halt rules.
module tb_phase_sequencer;

    localparam int DC = 4;
    localparam int NP = 5;
    localparam int PW = 3;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          exec_n = 1'b1;
    logic          step_mode = 1'b0;
    logic          halt = 1'b0;
    logic [PW-1:0] phase;
    logic          running, halted, exec_pulse;
    logic [CW-1:0] instr_count;

    phase_sequencer #(
        .DEBOUNCE_CYCLES(DC), .NUM_PHASES(NP), .PHASE_W(PW), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .exec_n(exec_n), .step_mode(step_mode),
        .halt(halt), .phase(phase), .running(running), .halted(halted),
        .exec_pulse(exec_pulse), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int pulse_seen = 0;

    bit hist[$];
    bit m_db, m_pulse, m_active, m_single, m_halted, m_stop;
    int m_phase, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DC + 2; i++) hist.push_back(1'b1);
        m_db = 1'b1; m_pulse = 1'b0; m_active = 1'b0; m_single = 1'b0;
        m_halted = 1'b0; m_stop = 1'b0; m_phase = 0; m_count = 0;
    endtask

    // hist holds exec_n as sampled at the last DC+2 edges; the oldest DC of them
    // are what the synchronizer output presented over the debounce window.
    task automatic model_step();
        bit flip;
        bit cur;
        if (reset) begin
            model_reset();
            return;
        end
        hist.push_back(exec_n);
        hist.delete(0);
        flip = 1'b1;
        for (int i = 0; i < DC; i++) if (hist[i] == m_db) flip = 1'b0;
        cur = m_pulse;
        if (!m_halted) begin
            if (!m_active) begin
                if (cur) begin m_active = 1'b1; m_single = step_mode; m_phase = 0; m_stop = 1'b0; end
            end else if (m_phase == NP - 1) begin
                m_phase = 0;
                m_count = (m_count + 1) % (1 << CW);
                if (halt)                  begin m_halted = 1'b1; m_active = 1'b0; m_stop = 1'b0; end
                else if (m_single || m_stop) begin m_active = 1'b0; m_stop = 1'b0; end
                else if (cur)              m_stop = 1'b1;
            end else begin
                m_phase++;
                if (cur && !m_single) m_stop = 1'b1;
            end
        end
        m_pulse = flip && m_db;
        if (flip) m_db = !m_db;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        if (exec_pulse) pulse_seen++;
        check("phase",       32'(phase),       32'(m_phase));
        check("running",     32'(running),     32'(m_active));
        check("halted",      32'(halted),      32'(m_halted));
        check("exec_pulse",  32'(exec_pulse),  32'(m_pulse));
        check("instr_count", 32'(instr_count), 32'(m_count));
    endtask

    // Called at posedge+1: raises reset mid-cycle and checks it acts before the next edge.
    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        check("ar_phase",   32'(phase),       0);
        check("ar_count",   32'(instr_count), 0);
        check("ar_running", 32'(running),     0);
        check("ar_halted",  32'(halted),      0);
        model_reset();
        tick();
        #2 reset = 1'b0;
    endtask

    task automatic press(input int low_ticks);
        exec_n = 1'b0;
        repeat (low_ticks) tick();
        exec_n = 1'b1;
    endtask

    task automatic wait_phase(input int p, input string tag);
        int n = 0;
        while (32'(phase) != p && n < 30) begin tick(); n++; end
        check(tag, 32'(phase), 32'(p));
    endtask

    initial begin
        int act;
        int n;
        model_reset();
        #12;
        check("rst_phase", 32'(phase), 0);
        check("rst_count", 32'(instr_count), 0);
        check("rst_running", 32'(running), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_pulse", 32'(exec_pulse), 0);
        reset = 1'b0;

        // short bounces never produce a pulse
        for (int r = 0; r < 3; r++) begin
            press(3);
            repeat (3) tick();
        end
        repeat (3) tick();
        check("glitch_pulses", pulse_seen, 0);

        // long press: pulse visible after edge 6, run starts, 3 instructions by edge 22
        pulse_seen = 0;
        exec_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) check("pulse_e5", 32'(exec_pulse), 0);
            if (k == 6) check("pulse_e6", 32'(exec_pulse), 1);
            if (k == 7) check("run_ph0", 32'(phase), 0);
        end
        exec_n = 1'b1;
        check("one_pulse", pulse_seen, 1);
        repeat (12) tick();
        check("run3_count", 32'(instr_count), 3);
        check("run3_running", 32'(running), 1);

        // stop press lands at phase 1; instruction completes, then idle
        exec_n = 1'b0;
        repeat (6) tick();
        check("stop_ph1", 32'(phase), 1);
        exec_n = 1'b1;
        repeat (6) tick();
        check("stop_running", 32'(running), 0);
        check("stop_phase", 32'(phase), 0);
        check("stop_count", 32'(instr_count), 5);

        // single step with a glitch and a step_mode change mid-instruction
        step_mode = 1'b1;
        act = 0;
        exec_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5)  exec_n = 1'b1;
            if (k == 8)  exec_n = 1'b0;
            if (k == 9)  step_mode = 1'b0;
            if (k == 11) exec_n = 1'b1;
            tick();
            if (running) act++;
        end
        check("step_active", act, 5);
        check("step_count", 32'(instr_count), 6);
        check("step_idle", 32'(running), 0);

        // halt only honoured in the last phase
        press(4);
        n = 0;
        while (!running && n < 20) begin tick(); n++; end
        check("halt_run", 32'(running), 1);
        wait_phase(2, "wait_ph2");
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_ignored", 32'(halted), 0);
        wait_phase(4, "wait_ph4");
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_set", 32'(halted), 1);
        check("halt_running", 32'(running), 0);
        check("halt_count", 32'(instr_count), 7);
        press(6);
        repeat (10) tick();
        check("halt_sticky", 32'(halted), 1);

        // async reset mid-run at phase 3 with count 7
        async_reset();
        press(4);
        n = 0;
        while (!(instr_count == 7 && phase == 3) && n < 100) begin tick(); n++; end
        check("reach_cnt7", 32'(instr_count), 7);
        check("reach_ph3", 32'(phase), 3);
        async_reset();
        repeat (5) tick();
        check("no_resume", 32'(running), 0);

        // randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            exec_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step_mode = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) begin
                halt = ($urandom_range(0, 150) == 0);
                tick();
            end
            halt = 1'b0;
            if ($urandom_range(0, 30) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the 3-bit instruction phase and run status consumed by the phase-pulse control stage.
- Debounces the raw active-low exec pushbutton into a single-cycle press pulse.
- Runs a run/step/idle/halted state machine and advances the phase 0..NUM_PHASES-1 each clock while active.
- Counts completed instructions.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before the debounced button level changes (>=2)
NUM_PHASES, 5, phases per instruction; phase runs 0..NUM_PHASES-1
PHASE_W, 3, phase output width; must satisfy 2^PHASE_W >= NUM_PHASES
CNT_W, 16, instruction counter width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
exec_n  in  1  raw exec pushbutton, active-low, asynchronous, bouncy
step_mode  in  1  level switch: 0 = continuous run, 1 = single instruction per press
halt  in  1  halt request from execute stage, sampled only in last phase
phase  out  PHASE_W  current phase index
running  out  1  high in RUN or STEP state
halted  out  1  high in HALTED state
exec_pulse  out  1  one-clock pulse per debounced press
instr_count  out  CNT_W  completed-instruction count

Behaviour:
- Reset (async, active-high) forces these values; sync flops do not sample while reset is high:
  - sync flops = 1, debounced level = 1, debounce counter = 0
  - state = IDLE, phase = 0, running = 0, halted = 0, exec_pulse = 0
  - instr_count = 0, stop_req = 0
- Input conditioning:
  - exec_n passes through a 2-flop synchronizer.
  - Debounce counter increments each clock the synced level differs from the debounced level. It clears when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on that edge and the counter clears.
- exec_pulse:
  - Registered; high for exactly one clock, the cycle after the debounced level goes 1->0.
  - Latency: first edge sampling exec_n low = edge 1. Debounced level falls at edge 2+DEBOUNCE_CYCLES. exec_pulse is high in the following cycle.
  - Release (0->1) produces no pulse.
  - Low glitches shorter than DEBOUNCE_CYCLES synced clocks produce no pulse.
- State machine (IDLE, RUN, STEP, HALTED):
  - IDLE: phase held 0, running 0.
    - exec_pulse -> STEP if step_mode=1, else RUN.
    - Phase is 0 in the first active cycle.
  - RUN: phase increments each clock, wrapping NUM_PHASES-1 -> 0.
    - Each wrap increments instr_count, which wraps all-ones -> 0.
    - exec_pulse in RUN sets stop_req; extra presses have no further effect.
    - At the wrap edge with stop_req=1: go IDLE, clear stop_req.
    - Stop never truncates an instruction.
  - STEP: phase advances as in RUN for exactly one instruction, then goes IDLE at the wrap edge. exec_pulse during STEP is ignored.
  - HALTED: phase 0, running 0, halted 1. Exit only by reset; exec_pulse ignored.
- Halt:
  - halt is sampled only when phase==NUM_PHASES-1 in RUN or STEP.
  - If high at that edge: instr_count increments, phase -> 0, state -> HALTED.
  - Halt has priority over stop_req and over STEP's return to IDLE.
  - halt in any other phase or state is ignored.
- step_mode is sampled only on the IDLE exit. Changing it mid-instruction has no effect.
- Outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Reset asserted mid-instruction aborts immediately: phase 0, counter 0. There is no partial-instruction count.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, NUM_PHASES=5.
1. exec_n low for 3 clocks, then high; repeat bounces -> exec_pulse never asserted. exec_n low for 10 clocks -> exactly one exec_pulse, high in the cycle after edge 6 counted from the first low sample.
2. step_mode=0, one press -> running=1, phase 0,1,2,3,4,0,1,... instr_count=1 after first wrap, 3 after 15 active clocks.
3. Stop: second press while RUN at phase 1 -> phases continue to 4. State IDLE and phase 0 after wrap; running=0; instr_count incremented for that instruction.
4. step_mode=1, one press -> exactly 5 active cycles (phase 0..4). Then IDLE, instr_count=1; extra press mid-step -> no second instruction.
5. Halt at phase 2 -> ignored. Halt at phase 4 -> halted=1, running=0, phase=0, count incremented. Later presses -> still HALTED until reset.
6. Assert reset asynchronously (between clock edges) during RUN at phase 3, instr_count=7 -> phase=0, instr_count=0, running=0, halted=0 before the next clock edge. Resume needs a new press.
